// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   8N1 UART receiver, LSB first. The asynchronous pin is synchronised by two
//   flops. The received byte is then placed in a one-byte holding register,
//   which the consumer drains through a valid/ready handshake.
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   uart_rx_async  in   raw serial line, idle high
//   rx_data        out  received byte, stable while rx_valid=1
//   rx_valid       out  holding register full
//   rx_ready       in   consumer takes rx_data when rx_valid & rx_ready
//   frame_error    out  1-cycle pulse: stop bit read as 0, byte discarded
//   overrun        out  1-cycle pulse: byte completed while holding reg full
// -----------------------------------------------------------------------------
module uart_receiver #(
    parameter int CLK_FREQUENCY_MHZ = 50,
    parameter int UART_BAUD_RATE    = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx_async,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_error,
    output logic       overrun
);

    localparam int CLKS_PER_BIT = (CLK_FREQUENCY_MHZ * 1_000_000) / UART_BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Synchroniser. It resets to 1 so that a reset looks like an idle line.
    logic [1:0] sync_q;
    logic       rx_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             commit_q, commit_d;
    logic             ferr_q, ferr_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    assign rx_s = sync_q[1];

    // NOTE: clocked state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= 2'b11;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            commit_q <= 1'b0;
            ferr_q   <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], uart_rx_async};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            commit_q <= commit_d;
            ferr_q   <= ferr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    // Frame sequencing: every sample is taken near the centre of its bit.
    always_comb begin
        // NOTE: every combinational output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        commit_d = 1'b0;
        ferr_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // If the line is high again here, the low level was a glitch.
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 1'b1;
                end
            end
            S_STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        commit_d = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        ferr_d   = 1'b1;
                        state_d  = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A line held low must return high before a new frame can start.
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Holding register. During the commit cycle shift_q is still intact,
    // because IDLE cannot start a new frame within a single cycle.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (commit_q) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d   = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign frame_error = ferr_q;
    assign overrun     = ovr_q;

endmodule
